cnn_layer_sequencer: RTL

- Frame-level controller for the conv -> relu -> pool -> fc datapath.
- Accepts one image's pixels from an upstream valid/ready source and feeds them to the datapath as registered pixel strobes.
- Clears the layers before each frame, waits out the pipeline latency, then captures the fc output and presents one result per frame on a valid/ready port.
- Sits between the frame source and the layer chain; the layer instances themselves are unchanged.

---
 rtl/cnn_pkg.sv | 23 ++
 rtl/cnn_pix_counter.sv | 57 +++++
 rtl/cnn_layer_sequencer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared types and defaults for the CNN layer sequencer.
// Holds the FSM state enum, default geometry and a counter-width helper.
package cnn_pkg;

   localparam int DATA_W_DEF   = 8;
   localparam int IMG_W_DEF    = 28;
   localparam int IMG_H_DEF    = 28;
   localparam int PIPE_LAT_DEF = 4;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      STREAM,
      DRAIN,
      OUTPUT
   } state_t;

   // Index width for a count of n, never narrower than one bit.
   function automatic int cw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cnn_pix_counter.sv
// Row/column position counter for one image frame.
// Ports: clk, rst (async high), clr (sync clear), adv (step one pixel),
// row/col (current position), last (position is the final pixel).
module cnn_pix_counter
   import cnn_pkg::*;
#(
   parameter int IMG_W = IMG_W_DEF,
   parameter int IMG_H = IMG_H_DEF
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 adv,
   output logic [cw(IMG_H)-1:0] row,
   output logic [cw(IMG_W)-1:0] col,
   output logic                 last
);

   localparam int RW = cw(IMG_H);
   localparam int CW = cw(IMG_W);
   localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);

   logic [RW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;
   logic          col_wrap;

   assign col_wrap = (col_q == COL_MAX);
   assign last     = col_wrap && (row_q == ROW_MAX);
   assign row      = row_q;
   assign col      = col_q;

   // Stepping past the final pixel wraps back to the origin.
   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (clr) begin
         row_d = '0;
         col_d = '0;
      end else if (adv) begin
         col_d = col_wrap ? '0 : col_q + CW'(1);
         if (col_wrap)
            row_d = (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_q <= '0;
         col_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Frame controller for the conv -> relu -> pool -> fc chain.
// Ports: start/abort control; s_* pixel input (valid/ready); layer_clr,
// pix_en/pix_out to conv; res_in from fc; res_* result output
// (valid/ready); busy, done, row/col status.
module cnn_layer_sequencer
   import cnn_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int IMG_W    = IMG_W_DEF,
   parameter int IMG_H    = IMG_H_DEF,
   parameter int PIPE_LAT = PIPE_LAT_DEF
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [DATA_W-1:0]    s_data,
   output logic                 layer_clr,
   output logic                 pix_en,
   output logic [DATA_W-1:0]    pix_out,
   input  logic [DATA_W-1:0]    res_in,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [DATA_W-1:0]    res_data,
   output logic                 busy,
   output logic                 done,
   output logic [cw(IMG_H)-1:0] row,
   output logic [cw(IMG_W)-1:0] col
);

   localparam int DRW = $clog2(PIPE_LAT + 1);

   state_t            state_q, state_d;
   logic              pix_en_q, pix_en_d;
   logic [DATA_W-1:0] pix_out_q, pix_out_d;
   logic              res_valid_q, res_valid_d;
   logic [DATA_W-1:0] res_data_q, res_data_d;
   logic              done_q, done_d;
   logic [DRW-1:0]    drain_q, drain_d;
   logic              accept, last, kill, take;

   assign kill   = abort && (state_q != IDLE);
   assign accept = s_valid && s_ready;
   assign take   = accept && !kill;

   cnn_pix_counter #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H)
   ) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (kill || (state_q == CLEAR)),
      .adv  (take),
      .row  (row),
      .col  (col),
      .last (last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // A start seen while done is still high belongs to the finished frame.
   always_comb begin
      state_d = state_q;
      if (kill) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE:    if (start && !done_q)     state_d = CLEAR;
            CLEAR:                             state_d = STREAM;
            STREAM:  if (accept && last)       state_d = DRAIN;
            DRAIN:   if (drain_q == '0)        state_d = OUTPUT;
            OUTPUT:  if (res_ready)            state_d = IDLE;
            default:                           state_d = IDLE;
         endcase
      end
   end

   // Drain count is loaded with the last accept, so it reads PIPE_LAT
   // in the cycle carrying the last pix_en and hits zero on capture.
   always_comb begin
      s_ready     = (state_q == STREAM);
      layer_clr   = (state_q == CLEAR);
      busy        = (state_q != IDLE);
      pix_en_d    = take;
      pix_out_d   = take ? s_data : pix_out_q;
      drain_d     = drain_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      done_d      = 1'b0;
      if (take && last)
         drain_d = DRW'(PIPE_LAT);
      else if (state_q == DRAIN && drain_q != '0)
         drain_d = drain_q - DRW'(1);
      if (kill) begin
         res_valid_d = 1'b0;
      end else if (state_q == DRAIN && drain_q == '0) begin
         res_valid_d = 1'b1;
         res_data_d  = res_in;
      end else if (state_q == OUTPUT && res_ready) begin
         res_valid_d = 1'b0;
         done_d      = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_en_q    <= 1'b0;
         pix_out_q   <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         done_q      <= 1'b0;
         drain_q     <= '0;
      end else begin
         pix_en_q    <= pix_en_d;
         pix_out_q   <= pix_out_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         done_q      <= done_d;
         drain_q     <= drain_d;
      end
   end

   assign pix_en    = pix_en_q;
   assign pix_out   = pix_out_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign done      = done_q;

endmodule
